// File: rtl/sdram_arbiter.sv
// Two-master arbiter for the single SDRAM controller port.
// The arbiter asks the owner to yield, and a burst in flight is never pre-empted.
module sdram_arbiter #(
  parameter int YIELD_TIMEOUT = 1024,
  parameter int HOLD_MIN      = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Want_0,
  input  logic        i_Want_1,
  output logic        o_Requested_0,
  output logic        o_Requested_1,
  input  logic        i_Yield_0,
  input  logic        i_Yield_1,
  input  logic [1:0]  i_Command_0,
  input  logic [1:0]  i_Command_1,
  input  logic [21:0] i_Address_0,
  input  logic [21:0] i_Address_1,
  input  logic [31:0] i_Write_Data_0,
  input  logic [31:0] i_Write_Data_1,
  output logic [1:0]  o_Command,
  output logic [21:0] o_Data_Address,
  output logic [31:0] o_Data_Write,
  input  logic        i_Data_Read_Valid,
  input  logic        i_Data_Write_Done,
  output logic        o_Read_Valid_0,
  output logic        o_Read_Valid_1,
  output logic        o_Write_Done_0,
  output logic        o_Write_Done_1,
  output logic        o_Owner,
  output logic        o_Timeout
);

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam int HW = $clog2(HOLD_MIN + 1);
  localparam int WW = $clog2(YIELD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    OWN_0,
    ASK_0,
    SWITCH_TO_1,
    OWN_1,
    ASK_1,
    SWITCH_TO_0
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;
  logic [21:0]   addr_q;
  logic [31:0]   data_q;

  logic          ownerSel;
  logic          isSwitch;
  logic          otherWant;
  logic          ownYield;
  logic [1:0]    ownCmd;
  logic [21:0]   ownAddr;
  logic [31:0]   ownData;

  // The grant stays with the old owner through its SWITCH dead cycle.
  always_comb begin
    ownerSel  = (state_q == OWN_1) || (state_q == ASK_1) || (state_q == SWITCH_TO_0);
    isSwitch  = (state_q == SWITCH_TO_0) || (state_q == SWITCH_TO_1);
    otherWant = ownerSel ? i_Want_0       : i_Want_1;
    ownYield  = ownerSel ? i_Yield_1      : i_Yield_0;
    ownCmd    = ownerSel ? i_Command_1    : i_Command_0;
    ownAddr   = ownerSel ? i_Address_1    : i_Address_0;
    ownData   = ownerSel ? i_Write_Data_1 : i_Write_Data_0;
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wait_d    = wait_q;
    timeout_d = 1'b0;
    case (state_q)
      OWN_0, OWN_1: begin
        wait_d = '0;
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (otherWant) begin
          state_d = (state_q == OWN_0) ? ASK_0 : ASK_1;
        end
      end
      ASK_0, ASK_1: begin
        // A yield counts only while the owner is idle; a timeout just pulses.
        if (ownYield && (ownCmd == CMD_IDLE)) begin
          state_d = (state_q == ASK_0) ? SWITCH_TO_1 : SWITCH_TO_0;
          wait_d  = '0;
        end else if (!otherWant) begin
          state_d = (state_q == ASK_0) ? OWN_0 : OWN_1;
          hold_d  = '0;
          wait_d  = '0;
        end else if (wait_q == WW'(YIELD_TIMEOUT - 1)) begin
          wait_d    = '0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      SWITCH_TO_1: begin
        state_d = OWN_1;
        hold_d  = HW'(HOLD_MIN);
        wait_d  = '0;
      end
      SWITCH_TO_0: begin
        state_d = OWN_0;
        hold_d  = HW'(HOLD_MIN);
        wait_d  = '0;
      end
      default: state_d = OWN_1;
    endcase
  end

  // Reset is also applied here so the pass-through paths go quiet immediately.
  always_comb begin
    o_Owner        = ownerSel;
    o_Requested_0  = (state_q == ASK_0);
    o_Requested_1  = (state_q == ASK_1);
    o_Command      = CMD_IDLE;
    o_Data_Address = '0;
    o_Data_Write   = '0;
    o_Read_Valid_0 = 1'b0;
    o_Read_Valid_1 = 1'b0;
    o_Write_Done_0 = 1'b0;
    o_Write_Done_1 = 1'b0;
    if (i_Rst_n) begin
      if (isSwitch) begin
        o_Data_Address = addr_q;
        o_Data_Write   = data_q;
      end else begin
        o_Command      = ownCmd;
        o_Data_Address = ownAddr;
        o_Data_Write   = ownData;
      end
      o_Read_Valid_0 = i_Data_Read_Valid & ~isSwitch & ~ownerSel;
      o_Read_Valid_1 = i_Data_Read_Valid & ~isSwitch &  ownerSel;
      o_Write_Done_0 = i_Data_Write_Done & ~isSwitch & ~ownerSel;
      o_Write_Done_1 = i_Data_Write_Done & ~isSwitch &  ownerSel;
    end
  end

  assign o_Timeout = timeout_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= OWN_1;
      hold_q    <= HW'(HOLD_MIN);
      wait_q    <= '0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      if (!isSwitch) begin
        addr_q <= ownAddr;
        data_q <= ownData;
      end
    end
  end

endmodule
